// File: rtl/mul_seq_ctrl.sv
// Sequential radix-4 shift-add unsigned multiplier, one 2-bit digit of B per cycle.
// Optional registered ovf output (Y >= 2**A_W) enabled by defining MUL_SEQ_OVF_EN.
module mul_seq_ctrl #(
  parameter int A_W = 4,
  parameter int B_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [A_W-1:0]   A,
  input  logic [B_W-1:0]   B,
  output logic             busy,
  output logic             done,
  output logic [A_W+B_W-1:0] Y
`ifdef MUL_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int ND  = B_W / 2;
  localparam int P_W = A_W + B_W;
  localparam int CW  = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [A_W-1:0] a_reg, a_n;
  logic [B_W-1:0] b_reg, b_n;
  logic [P_W-1:0] acc, acc_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [P_W-1:0] y_n;

  logic [1:0]     digit;
  logic [A_W+1:0] pp;
  logic [P_W-1:0] term;
  logic [P_W-1:0] sum;
  logic           last;

`ifdef MUL_SEQ_OVF_EN
  logic ovf_n;
`endif

  // digit k of B_reg, weighted into place by 4**k
  always_comb begin
    digit = 2'(b_reg >> {cnt, 1'b0});
    pp    = {2'b00, a_reg} * {{A_W{1'b0}}, digit};
    term  = P_W'(pp) << {cnt, 1'b0};
    sum   = acc + term;
    last  = (cnt == CW'(ND - 1));
  end

  always_comb begin
    state_n = state;
    a_n     = a_reg;
    b_n     = b_reg;
    acc_n   = acc;
    cnt_n   = cnt;
    y_n     = Y;
`ifdef MUL_SEQ_OVF_EN
    ovf_n   = ovf;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CALC;
          a_n     = A;
          b_n     = B;
          acc_n   = '0;
          cnt_n   = '0;
        end
      end
      CALC: begin
        acc_n = sum;
        cnt_n = cnt + CW'(1);
        if (last) begin
          state_n = DONE;
          y_n     = sum;
`ifdef MUL_SEQ_OVF_EN
          ovf_n   = |sum[P_W-1:A_W];
`endif
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      Y     <= '0;
`ifdef MUL_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      a_reg <= a_n;
      b_reg <= b_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      Y     <= y_n;
`ifdef MUL_SEQ_OVF_EN
      ovf   <= ovf_n;
`endif
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: reset, latency, ignore-while-busy,
// abort on reset, and all 256 default-width operand pairs back to back.
module tb_mul_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] Y;
`ifdef MUL_SEQ_OVF_EN
  logic       ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.A_W(4), .B_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Y     (Y)
`ifdef MUL_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: start in IDLE, then watch six cycles for the done pulse.
  // With disturb set, a second start and new operands arrive during CALC.
  task automatic op(input string tag, input logic [3:0] a,
                    input logic [3:0] b, input logic [7:0] ey,
                    input logic eovf, input bit disturb);
    int pulses;
    int at;
    pulses = 0;
    at     = -1;
    A      = a;
    B      = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (disturb) begin
      start = 1'b1;
      A     = 4'd1;
      B     = 4'd1;
    end
    for (int i = 0; i < 6; i++) begin
      if (done) begin
        pulses++;
        if (at < 0) at = i;
      end
      if (i == 1) start = 1'b0;
      tick();
    end
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_lat"}, 32'(at), 32'd2);
    chk({tag, "_y"}, 32'(Y), 32'(ey));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
`ifdef MUL_SEQ_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("note: %s ovf unknown", tag);
`endif
  endtask

  initial begin
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(Y), 32'h00);
`ifdef MUL_SEQ_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    op("m15x15", 4'd15, 4'd15, 8'hE1, 1'b1, 1'b0);
    op("m3x5", 4'd3, 4'd5, 8'h0F, 1'b0, 1'b0);
    op("m4x4", 4'd4, 4'd4, 8'h10, 1'b1, 1'b0);
    op("m7x9_busy", 4'd7, 4'd9, 8'h3F, 1'b1, 1'b1);
    op("m0x15", 4'd0, 4'd15, 8'h00, 1'b0, 1'b0);
    op("m15x0", 4'd15, 4'd0, 8'h00, 1'b0, 1'b0);

    // Abort in the first CALC cycle.
    A     = 4'd15;
    B     = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_y", 32'(Y), 32'h00);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) pulses++;
      tick();
    end
    chk("abort_nopulse", 32'(pulses), 32'd0);
    op("m2x3", 4'd2, 4'd3, 8'h06, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    A     = 4'd5;
    B     = 4'd5;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("prio_busy", 32'(busy), 32'd0);
    chk("prio_y", 32'(Y), 32'h00);
    tick();
    chk("prio_stay", 32'(busy), 32'd0);

    // Back to back: start on each first IDLE cycle, 4-cycle period.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A     = 4'(a);
        B     = 4'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = 4'(15 - a);
        B     = 4'(15 - b);
        tick();
        chk("ex_calc", 32'(done), 32'd0);
        tick();
        chk("ex_done", 32'(done), 32'd1);
        chk("ex_y", 32'(Y), 32'(a * b));
        tick();
        chk("ex_idle", 32'(busy), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
